// File: rtl/wm_pkg.sv
// Shared types for the washing-machine programme controller.
// - wm_state_e: 4-bit state codes. They also drive the phase status output, so
//   the numbering is fixed for display logic.
// - PHASE_W: width of the phase status field.
// - limit_ok(): checks that a cycle-count parameter fits the timer.
package wm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_READY = 4'd1,
    ST_FILL  = 4'd2,
    ST_HEAT  = 4'd3,
    ST_SOAK  = 4'd4,
    ST_WASH  = 4'd5,
    ST_RINSE = 4'd6,
    ST_SPIN  = 4'd7,
    ST_FAULT = 4'd8
  } wm_state_e;

  localparam int PHASE_W = 4;

  // Timed phases: these are the phases that the lid can freeze.
  function automatic logic is_timed(input wm_state_e s);
    return (s == ST_SOAK) || (s == ST_WASH) || (s == ST_RINSE) || (s == ST_SPIN);
  endfunction

  // The count n must be at least 1, and the terminal value n-1 must fit in w bits.
  function automatic bit limit_ok(input int n, input int w);
    return (n >= 1) && (((n - 1) >> w) == 0);
  endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Phase / timeout counter.
// - clock, reset_n: clock and asynchronous active-low reset.
// - clear: forces the count back to 0. This takes priority over enable.
// - en: counts one step per cycle. It is deasserted while the controller is paused.
// - limit: terminal value of the current phase.
// - tc: high when the count equals limit.
// The counter stops at the limit, so it can never wrap.
module wm_phase_timer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  assign tc = (count == limit);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       count <= '0;
    else if (clear)     count <= '0;
    else if (en && !tc) count <= count + 1'b1;
  end

endmodule

// File: rtl/wm_cycle_controller.sv
// Washing-machine programme controller.
// Programme sequence: IDLE -> READY -> FILL -> HEAT -> SOAK -> WASH ->
// RINSE x RINSE_COUNT -> SPIN -> IDLE.
// Additional behaviour:
// - FILL and HEAT time out to FAULT.
// - An open lid pauses the timed phases.
// - cancel drains the machine through SPIN.
// - cancel refunds the coin from READY and from FAULT.
// Ports:
// - Inputs: lid, coin, cancel, fill_water, heat_water, wash. These come from
//   the panel and the sensors.
// - Status outputs: idle, ready, paused, fault, phase, rinse_index.
// - Actuator outputs: soak_operation, wash_operation, rinse_operation,
//   spin_operation, water_intake, heater_on.
// - coin_return: a registered one-cycle refund pulse.
import wm_pkg::*;

module wm_cycle_controller #(
  parameter int TIMER_WIDTH  = 16,
  parameter int SOAK_CYCLES  = 100,
  parameter int WASH_CYCLES  = 200,
  parameter int RINSE_CYCLES = 150,
  parameter int SPIN_CYCLES  = 120,
  parameter int RINSE_COUNT  = 2,
  parameter int FILL_TIMEOUT = 500,
  parameter int HEAT_TIMEOUT = 800
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               lid,
  input  logic               coin,
  input  logic               cancel,
  input  logic               fill_water,
  input  logic               heat_water,
  input  logic               wash,
  output logic               idle,
  output logic               ready,
  output logic               soak_operation,
  output logic               wash_operation,
  output logic               rinse_operation,
  output logic               spin_operation,
  output logic               coin_return,
  output logic               water_intake,
  output logic               heater_on,
  output logic               paused,
  output logic               fault,
  output logic [PHASE_W-1:0] phase,
  output logic [3:0]         rinse_index
);

  if (!limit_ok(SOAK_CYCLES, TIMER_WIDTH) || !limit_ok(WASH_CYCLES, TIMER_WIDTH) ||
      !limit_ok(RINSE_CYCLES, TIMER_WIDTH) || !limit_ok(SPIN_CYCLES, TIMER_WIDTH) ||
      !limit_ok(FILL_TIMEOUT, TIMER_WIDTH) || !limit_ok(HEAT_TIMEOUT, TIMER_WIDTH) ||
      RINSE_COUNT < 1 || RINSE_COUNT > 15) begin : g_bad_param
    $error("wm_cycle_controller: cycle parameter out of range for TIMER_WIDTH");
  end

  localparam logic [TIMER_WIDTH-1:0] L_FILL  = TIMER_WIDTH'(FILL_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] L_HEAT  = TIMER_WIDTH'(HEAT_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] L_SOAK  = TIMER_WIDTH'(SOAK_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] L_WASH  = TIMER_WIDTH'(WASH_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] L_RINSE = TIMER_WIDTH'(RINSE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] L_SPIN  = TIMER_WIDTH'(SPIN_CYCLES - 1);

  wm_state_e              state, state_nx;
  logic [TIMER_WIDTH-1:0] limit;
  logic                   tmr_en, tmr_clr, tc;
  logic                   restart, rinse_inc, rinse_clr, coin_ret_nx;

  wm_phase_timer #(.W(TIMER_WIDTH)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmr_clr),
    .en      (tmr_en),
    .limit   (limit),
    .tc      (tc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      rinse_index <= '0;
      coin_return <= 1'b0;
    end else begin
      state       <= state_nx;
      coin_return <= coin_ret_nx;
      if (rinse_clr)      rinse_index <= '0;
      else if (rinse_inc) rinse_index <= rinse_index + 4'd1;
    end
  end

  // In a timed phase, cancel is checked before the lid state, so a cancel
  // still takes effect while the phase is paused.
  always_comb begin
    state_nx    = state;
    limit       = '0;
    tmr_en      = 1'b0;
    restart     = 1'b0;
    rinse_inc   = 1'b0;
    rinse_clr   = 1'b0;
    coin_ret_nx = 1'b0;
    unique case (state)
      ST_IDLE:  if (coin) state_nx = ST_READY;
      ST_READY: begin
        if (cancel) begin
          state_nx    = ST_IDLE;
          coin_ret_nx = 1'b1;
        end else if (wash && lid) state_nx = ST_FILL;
      end
      ST_FILL: begin
        tmr_en = 1'b1;
        limit  = L_FILL;
        if (cancel)          state_nx = ST_SPIN;
        else if (fill_water) state_nx = ST_HEAT;
        else if (tc)         state_nx = ST_FAULT;
      end
      ST_HEAT: begin
        tmr_en = 1'b1;
        limit  = L_HEAT;
        if (cancel)          state_nx = ST_SPIN;
        else if (heat_water) state_nx = ST_SOAK;
        else if (tc)         state_nx = ST_FAULT;
      end
      ST_SOAK: begin
        tmr_en = lid;
        limit  = L_SOAK;
        if (cancel)         state_nx = ST_SPIN;
        else if (lid && tc) state_nx = ST_WASH;
      end
      ST_WASH: begin
        tmr_en = lid;
        limit  = L_WASH;
        if (cancel)         state_nx = ST_SPIN;
        else if (lid && tc) state_nx = ST_RINSE;
      end
      ST_RINSE: begin
        tmr_en = lid;
        limit  = L_RINSE;
        if (cancel) state_nx = ST_SPIN;
        else if (lid && tc) begin
          rinse_inc = 1'b1;
          if (({1'b0, rinse_index} + 5'd1) < 5'(RINSE_COUNT)) restart = 1'b1;
          else                                                state_nx = ST_SPIN;
        end
      end
      ST_SPIN: begin
        tmr_en = lid;
        limit  = L_SPIN;
        if (lid && tc) begin
          state_nx  = ST_IDLE;
          rinse_clr = 1'b1;
        end
      end
      ST_FAULT: begin
        if (cancel) begin
          state_nx    = ST_IDLE;
          coin_ret_nx = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // A new rinse pass stays in the same state, so it needs its own timer restart.
    tmr_clr = (state_nx != state) || restart;
  end

  assign paused          = is_timed(state) && !lid;
  assign idle            = (state == ST_IDLE);
  assign ready           = (state == ST_READY);
  assign soak_operation  = (state == ST_SOAK)  && !paused;
  assign wash_operation  = (state == ST_WASH)  && !paused;
  assign rinse_operation = (state == ST_RINSE) && !paused;
  assign spin_operation  = (state == ST_SPIN)  && !paused;
  assign water_intake    = (state == ST_FILL) || rinse_operation;
  assign heater_on       = (state == ST_HEAT);
  assign fault           = (state == ST_FAULT);
  assign phase           = state;

endmodule

// File: tb/tb_wm_cycle_controller.sv
module tb_wm_cycle_controller;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic lid = 1'b0, coin = 1'b0, cancel = 1'b0, fill_water = 1'b0, heat_water = 1'b0, wash = 1'b0;
  logic idle, ready, soak_operation, wash_operation, rinse_operation, spin_operation;
  logic coin_return, water_intake, heater_on, paused, fault;
  logic [3:0] phase, rinse_index;

  always #5 clock = ~clock;

  wm_cycle_controller #(
    .TIMER_WIDTH(8), .SOAK_CYCLES(3), .WASH_CYCLES(4), .RINSE_CYCLES(2),
    .SPIN_CYCLES(3), .RINSE_COUNT(2), .FILL_TIMEOUT(5), .HEAT_TIMEOUT(6)
  ) dut (
    .clock(clock), .reset_n(reset_n), .lid(lid), .coin(coin), .cancel(cancel),
    .fill_water(fill_water), .heat_water(heat_water), .wash(wash),
    .idle(idle), .ready(ready), .soak_operation(soak_operation),
    .wash_operation(wash_operation), .rinse_operation(rinse_operation),
    .spin_operation(spin_operation), .coin_return(coin_return),
    .water_intake(water_intake), .heater_on(heater_on), .paused(paused),
    .fault(fault), .phase(phase), .rinse_index(rinse_index)
  );

  localparam logic [3:0] I = 4'd0, RD = 4'd1, FL = 4'd2, HT = 4'd3, SK = 4'd4,
                         WS = 4'd5, RN = 4'd6, SP = 4'd7, FT = 4'd8;

  typedef struct {
    logic       l, c, cn, f, h, w;
    logic [3:0] ph, ri;
    logic       cr, pz;
  } vec_t;

  vec_t tbl[20];
  vec_t q[$];
  int   n_cmp = 0, n_bad = 0;

  function automatic vec_t mk(input logic l, c, cn, f, h, w,
                              input logic [3:0] ph, ri, input logic cr, pz);
    vec_t v;
    v.l = l; v.c = c; v.cn = cn; v.f = f; v.h = h; v.w = w;
    v.ph = ph; v.ri = ri; v.cr = cr; v.pz = pz;
    return v;
  endfunction

  // Output vector expected from the stated state/rinse/refund/pause values.
  function automatic logic [18:0] expect_of(input vec_t e);
    logic run;
    run = !e.pz;
    return {e.ph == I, e.ph == RD, e.ph == SK && run, e.ph == WS && run,
            e.ph == RN && run, e.ph == SP && run, e.cr,
            e.ph == FL || (e.ph == RN && run), e.ph == HT, e.pz, e.ph == FT,
            e.ph, e.ri};
  endfunction

  function automatic logic [18:0] actual();
    return {idle, ready, soak_operation, wash_operation, rinse_operation,
            spin_operation, coin_return, water_intake, heater_on, paused,
            fault, phase, rinse_index};
  endfunction

  task automatic check(input string tag);
    vec_t e;
    logic [18:0] a, x;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = q.pop_front();
    a = actual();
    x = expect_of(e);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got outs=%b phase=%0d ri=%0d, want outs=%b phase=%0d ri=%0d",
               tag, a[18:8], a[7:4], a[3:0], x[18:8], x[7:4], x[3:0]);
    end
  endtask

  task automatic cyc(input string tag, input vec_t v);
    lid = v.l; coin = v.c; cancel = v.cn; fill_water = v.f; heat_water = v.h; wash = v.w;
    q.push_back(v);
    @(posedge clock);
    #1;
    check(tag);
  endtask

  task automatic c(input string tag, input logic l, cc, cn, f, h, w,
                   input logic [3:0] ph, ri, input logic cr, pz);
    cyc(tag, mk(l, cc, cn, f, h, w, ph, ri, cr, pz));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    lid = 0; coin = 0; cancel = 0; fill_water = 0; heat_water = 0; wash = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    q.push_back(mk(0, 0, 0, 0, 0, 0, I, 0, 0, 0));
    check("reset_state");
  endtask

  initial begin
    // Full programme table. Each row lists the inputs, then the state after the edge.
    tbl[0]  = mk(1,1,0,0,0,0, RD,0,0,0);
    tbl[1]  = mk(1,0,0,0,0,1, FL,0,0,0);
    tbl[2]  = mk(1,0,0,0,0,0, FL,0,0,0);
    tbl[3]  = mk(1,0,0,1,0,0, HT,0,0,0);
    tbl[4]  = mk(1,0,0,0,0,0, HT,0,0,0);
    tbl[5]  = mk(1,0,0,0,1,0, SK,0,0,0);
    tbl[6]  = mk(1,0,0,0,0,0, SK,0,0,0);
    tbl[7]  = mk(1,0,0,0,0,0, SK,0,0,0);
    tbl[8]  = mk(1,0,0,0,0,0, WS,0,0,0);
    tbl[9]  = mk(1,0,0,0,0,0, WS,0,0,0);
    tbl[10] = mk(1,0,0,0,0,0, WS,0,0,0);
    tbl[11] = mk(1,0,0,0,0,0, WS,0,0,0);
    tbl[12] = mk(1,0,0,0,0,0, RN,0,0,0);
    tbl[13] = mk(1,0,0,0,0,0, RN,0,0,0);
    tbl[14] = mk(1,0,0,0,0,0, RN,1,0,0);
    tbl[15] = mk(1,0,0,0,0,0, RN,1,0,0);
    tbl[16] = mk(1,0,0,0,0,0, SP,2,0,0);
    tbl[17] = mk(1,0,0,0,0,0, SP,2,0,0);
    tbl[18] = mk(1,0,0,0,0,0, SP,2,0,0);
    tbl[19] = mk(1,0,0,0,0,0, I, 0,0,0);

    do_reset();
    for (int i = 0; i < 20; i++) cyc($sformatf("full_run[%0d]", i), tbl[i]);

    // A cancel in READY beats wash and refunds the coin for exactly one cycle.
    c("rdy_coin",   0,1,0,0,0,0, RD,0,0,0);
    c("rdy_cancel", 1,0,1,0,0,1, I, 0,1,0);
    c("rdy_after",  1,0,0,0,0,0, I, 0,0,0);

    // FILL times out after 5 cycles. A cancel from FAULT refunds the coin.
    c("to_coin", 1,1,0,0,0,0, RD,0,0,0);
    c("to_wash", 1,0,0,0,0,1, FL,0,0,0);
    for (int i = 0; i < 4; i++) c($sformatf("to_fill[%0d]", i), 1,0,0,0,0,0, FL,0,0,0);
    c("to_fault",  1,0,0,0,0,0, FT,0,0,0);
    c("to_hold",   1,1,0,1,0,1, FT,0,0,0);
    c("to_cancel", 1,0,1,0,0,0, I, 0,1,0);
    c("to_after",  1,0,0,0,0,0, I, 0,0,0);

    // fill_water on the timeout cycle wins. Then a cancel in HEAT drains
    // through SPIN with no refund.
    c("tie_coin", 1,1,0,0,0,0, RD,0,0,0);
    c("tie_wash", 1,0,0,0,0,1, FL,0,0,0);
    for (int i = 0; i < 4; i++) c($sformatf("tie_fill[%0d]", i), 1,0,0,0,0,0, FL,0,0,0);
    c("tie_heat",   1,0,0,1,0,0, HT,0,0,0);
    c("tie_cancel", 1,0,1,0,0,0, SP,0,0,0);
    c("tie_spin1",  1,0,0,0,0,0, SP,0,0,0);
    c("tie_spin2",  1,0,0,0,0,0, SP,0,0,0);
    c("tie_idle",   1,0,0,0,0,0, I, 0,0,0);

    // Open the lid during WASH after 2 counted cycles. Then cancel in rinse pass 1.
    c("pz_coin", 1,1,0,0,0,0, RD,0,0,0);
    c("pz_wash", 1,0,0,0,0,1, FL,0,0,0);
    c("pz_fill", 1,0,0,1,0,0, HT,0,0,0);
    c("pz_heat", 1,0,0,0,1,0, SK,0,0,0);
    c("pz_soak1", 1,0,0,0,0,0, SK,0,0,0);
    c("pz_soak2", 1,0,0,0,0,0, SK,0,0,0);
    c("pz_w0", 1,0,0,0,0,0, WS,0,0,0);
    c("pz_w1", 1,0,0,0,0,0, WS,0,0,0);
    c("pz_w2", 1,0,0,0,0,0, WS,0,0,0);
    for (int i = 0; i < 10; i++) c($sformatf("pz_lid_open[%0d]", i), 0,0,0,0,0,0, WS,0,0,1);
    c("pz_resume", 1,0,0,0,0,0, WS,0,0,0);
    c("pz_rinse",  1,0,0,0,0,0, RN,0,0,0);
    c("rc_cancel", 1,0,1,0,0,0, SP,0,0,0);
    c("rc_spin_cancel_ignored", 1,0,1,0,0,0, SP,0,0,0);
    c("rc_spin2",  1,0,0,0,0,0, SP,0,0,0);
    c("rc_idle",   1,0,0,0,0,0, I, 0,0,0);

    // An asynchronous reset mid-SPIN, with rinse_index at 2, takes effect with no clock edge.
    for (int i = 0; i < 17; i++) cyc($sformatf("pre_rst[%0d]", i), tbl[i]);
    #2;
    reset_n = 1'b0;
    #1;
    q.push_back(mk(1, 0, 0, 0, 0, 0, I, 0, 0, 0));
    check("async_reset");
    #2;
    reset_n = 1'b1;
    c("post_rst", 1,0,0,0,0,0, I,0,0,0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
